// File: rtl/signed_divider.sv
// Signed restoring divider for two's-complement operands.
// Division runs on unsigned magnitudes, one quotient bit per cycle, and the
// signs are applied in a final fix-up cycle. A zero divisor bypasses the
// iteration and produces an all-ones quotient immediately. Results are held
// until the consumer takes them via the valid/ready handshake.
module signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Two's-complement negation; also used to form operand magnitudes.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a signed value. The most-negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? negate(v) : v;
  endfunction

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvsr;     // divisor magnitude
  logic [WIDTH-1:0] r_quo;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_rem;      // partial remainder (always < divisor magnitude)
  logic             r_neg_q;    // operand signs differ
  logic             r_neg_r;    // dividend negative
  logic             r_ovf;      // most-negative / -1 detected at accept
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;
  logic             r_overflow;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_divisor_zero;
  logic             w_ovf_case;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // Handshake decode and one restoring shift-subtract step.
  always_comb begin
    w_in_ready     = (r_state == IDLE) && !rst;
    w_accept       = in_valid && w_in_ready;
    w_divisor_zero = (divisor == {WIDTH{1'b0}});
    w_ovf_case     = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (divisor == {WIDTH{1'b1}});
    w_rem_shift    = {r_rem, r_quo[WIDTH-1]};
    w_diff         = w_rem_shift - {1'b0, r_dvsr};
    w_q_bit        = ~w_diff[WIDTH];
    w_rem_next     = w_q_bit ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    w_quo_next     = {r_quo[WIDTH-2:0], w_q_bit};
  end

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= {CW{1'b0}};
      r_dvsr        <= {WIDTH{1'b0}};
      r_quo         <= {WIDTH{1'b0}};
      r_rem         <= {WIDTH{1'b0}};
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_ovf         <= 1'b0;
      r_quotient    <= {WIDTH{1'b0}};
      r_remainder   <= {WIDTH{1'b0}};
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_divisor_zero) begin
              r_quotient    <= {WIDTH{1'b1}};
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
              r_overflow    <= 1'b0;
              r_state       <= DONE;
            end else begin
              r_dvsr  <= magnitude(divisor);
              r_quo   <= magnitude(dividend);
              r_rem   <= {WIDTH{1'b0}};
              r_cnt   <= CW'(WIDTH - 1);
              r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_neg_r <= dividend[WIDTH-1];
              r_ovf   <= w_ovf_case;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt == {CW{1'b0}}) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          // Overflow case falls out naturally: magnitude 2^(WIDTH-1), signs
          // equal, so the wrapped quotient is the most-negative value.
          r_quotient    <= r_neg_q ? negate(r_quo) : r_quo;
          r_remainder   <= r_neg_r ? negate(r_rem) : r_rem;
          r_div_by_zero <= 1'b0;
          r_overflow    <= r_ovf;
          r_state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule
